// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: two-master, one-slave arbiter for the MIPS memory bus.
// Master 0 is the CPU port and master 1 is the loader/DMA port. Both share one
// RAM/bus slave using a waitrequest handshake, with round-robin on ties.
//
// Optional feature macro: MIPS_ARB_LOCK_EN
//   When it is defined, the m0_lock and m1_lock inputs are added. A locked
//   master keeps the bus across back-to-back transactions, which supports
//   read-modify-write sequences. When it is undefined, every completed
//   transaction returns to IDLE.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner, grant=00; arbitrate among pending requests
// ACCESS  | granted master muxed onto the slave; wait for acceptance
// RDATA   | slave returns read data; granted master released this cycle

module mips_bus_arbiter #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
`ifdef MIPS_ARB_LOCK_EN
  input  logic              m0_lock,
`endif

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
`ifdef MIPS_ARB_LOCK_EN
  input  logic              m1_lock,
`endif

  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,

  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  // Set when master 1 held the most recent grant; resets to 1 so that
  // master 0 wins the first tie after reset.
  logic        last_m1_q, last_m1_d;

  logic              m0_req, m1_req;
  logic              sel_m1;
  logic [ADDR_W-1:0] sel_address;
  logic              sel_read, sel_write, sel_req, sel_lock;
  logic [DATA_W-1:0] sel_writedata;
  logic [BE_W-1:0]   sel_byteenable;

  // Port-level request view of each master, plus the granted master's bus.
  always_comb begin
    m0_req         = m0_read | m0_write;
    m1_req         = m1_read | m1_write;
    sel_m1         = grant_q[1];
    sel_address    = sel_m1 ? m1_address    : m0_address;
    sel_read       = sel_m1 ? m1_read       : m0_read;
    sel_write      = sel_m1 ? m1_write      : m0_write;
    sel_writedata  = sel_m1 ? m1_writedata  : m0_writedata;
    sel_byteenable = sel_m1 ? m1_byteenable : m0_byteenable;
    sel_req        = sel_read | sel_write;
  end

`ifdef MIPS_ARB_LOCK_EN
  // Lock of whichever master currently owns the bus.
  always_comb begin
    sel_lock = sel_m1 ? m1_lock : m0_lock;
  end
`else
  // Without the lock feature every completion re-arbitrates.
  always_comb begin
    sel_lock = 1'b0;
  end
`endif

  // State register; an async reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      last_m1_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_m1_q <= last_m1_d;
    end
  end

  // Next-state logic plus all slave-side and master-side outputs.
  always_comb begin
    logic release_sel;
    logic return_rd;

    state_d        = state_q;
    grant_d        = grant_q;
    last_m1_d      = last_m1_q;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    release_sel    = 1'b0;
    return_rd      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_d = 2'b00;
        if (m0_req && m1_req) begin
          // Round-robin: the master that did not own the bus last goes first.
          if (last_m1_q) begin
            grant_d   = 2'b01;
            last_m1_d = 1'b0;
          end else begin
            grant_d   = 2'b10;
            last_m1_d = 1'b1;
          end
          state_d = ST_ACCESS;
        end else if (m0_req) begin
          grant_d   = 2'b01;
          last_m1_d = 1'b0;
          state_d   = ST_ACCESS;
        end else if (m1_req) begin
          grant_d   = 2'b10;
          last_m1_d = 1'b1;
          state_d   = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (!sel_req) begin
          // The owner withdrew mid-access: drop the slave strobes and give up the bus.
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else begin
          s_address    = sel_address;
          s_writedata  = sel_writedata;
          s_byteenable = sel_byteenable;
          s_write      = sel_write;
          // When read and write are both asserted, only the write is forwarded.
          s_read       = sel_read & ~sel_write;
          if (!s_waitrequest) begin
            if (sel_write) begin
              release_sel = 1'b1;
              if (sel_lock) begin
                state_d = ST_ACCESS;
              end else begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
              end
            end else begin
              state_d = ST_RDATA;
            end
          end
        end
      end

      ST_RDATA: begin
        release_sel = 1'b1;
        return_rd   = 1'b1;
        // Lock only keeps the bus if the owner already presents its next request.
        if (sel_lock && sel_req) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase

    // Only the owning master is ever released; the other master stays stalled with zero data.
    if (release_sel) begin
      if (sel_m1) m1_waitrequest = 1'b0;
      else        m0_waitrequest = 1'b0;
    end
    if (return_rd) begin
      if (sel_m1) m1_readdata = s_readdata;
      else        m0_readdata = s_readdata;
    end
  end

  assign grant = grant_q;

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Two-master, one-slave arbiter for the MIPS memory bus (address/read/write/writedata/byteenable/readdata/waitrequest). It shares a single RAM/bus slave between master 0 (CPU instruction/data port) and master 1 (loader/DMA/second port). It sits between the masters and the memory model. Each master sees a basic waitrequest protocol: readdata is valid in the cycle its waitrequest drops.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; must be a multiple of 8
BE_W, DATA_W/8, byteenable width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
m0_address  in  ADDR_W  master 0 byte address
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_byteenable  in  BE_W  master 0 byte lanes
m0_readdata  out  DATA_W  master 0 read data
m0_waitrequest  out  1  master 0 stall
m1_*  same set and directions as m0_*, for master 1
s_address  out  ADDR_W  slave address
s_read  out  1  slave read strobe
s_write  out  1  slave write strobe
s_writedata  out  DATA_W  slave write data
s_byteenable  out  BE_W  slave byte lanes
s_readdata  in  DATA_W  slave read data; valid 1 cycle after read accepted
s_waitrequest  in  1  slave stall
grant  out  2  one-hot current owner ({m1,m0}); 2'b00 when idle

Behaviour:
- Reset (reset==0, async): state=IDLE, last_grant=1 (so m0 wins first tie), grant=00, s_read=s_write=0, s_address/s_writedata/s_byteenable=0, m*_waitrequest=1, m*_readdata=0. Reset mid-transaction aborts immediately, with no further slave strobes.
- Request: mX_req = mX_read | mX_write. If both are high, the write is forwarded and the read is ignored.
- States: IDLE, ACCESS, RDATA.
- IDLE: no request -> stay, grant=00. Single request -> grant that master, go to ACCESS next cycle. Both request -> round-robin: grant the master not in last_grant. Update last_grant on every grant.
- ACCESS: slave signals are combinationally muxed from the granted master; s_read/s_write follow the master strobes.
  - Write accepted (s_write & !s_waitrequest): granted mX_waitrequest=0 in that same cycle, then go to IDLE.
  - Read accepted (s_read & !s_waitrequest): mX_waitrequest stays 1, go to RDATA.
  - Slave stalled: hold ACCESS indefinitely (no timeout).
  - Master drops its request in ACCESS (protocol violation): return to IDLE, with no slave strobe that cycle.
- RDATA: s_read=s_write=0. mX_readdata=s_readdata and mX_waitrequest=0 for exactly this one cycle, then go to IDLE.
- The non-granted master always sees waitrequest=1 and readdata=0.
- Throughput: a zero-wait write takes 2 cycles (IDLE, ACCESS). A zero-wait read takes 3 cycles (IDLE, ACCESS, RDATA).
- Back-to-back: returning to IDLE re-arbitrates. Two continuously requesting masters alternate strictly.
- byteenable is passed through unchanged; the arbiter performs no address translation.

Optional Feature:
MIPS_ARB_LOCK_EN.
- Defined: adds inputs m0_lock and m1_lock (1 bit each).
  - If the granted master holds lock high when its transaction completes, the state goes directly to ACCESS for the same master. There is no IDLE cycle and no re-arbitration, which suits read-modify-write sequences.
  - Lock is ignored while the master has no request; the arbiter then returns to IDLE.
- Undefined: no lock ports; every completion returns to IDLE.

Test Plan:
- Reset: hold reset=0 with m0_read=1 -> s_read=0, m0_waitrequest=1, grant=00. Release reset -> grant=01 on the next edge, and s_address=m0_address=0xBFC00000.
- Single read: m0 reads 0xBFC00004, s_waitrequest=0, memory returns 0x0000F100 -> m0_waitrequest low for exactly 1 cycle, in the RDATA cycle, with m0_readdata=0x0000F100. The transaction takes 3 cycles.
- Contention: m0 and m1 both write continuously (m0 data 0x11111111 to 0xBFC00008, m1 data 0x22222222 to 0xBFC0000C) -> grant sequence 01,10,01,10. Memory ends holding both values, and neither master starves.
- Slave stall: m1 writes with byteenable=4'b0011 while s_waitrequest=1 for 5 cycles -> s_write stays high and m1_waitrequest=1 for 5 cycles, then drops on acceptance. Only the low 16 bits are written.
- Reset mid-read: assert reset in RDATA -> in the same cycle all slave strobes drop and m*_waitrequest=1. After release, arbitration restarts with m0 favoured.
- MIPS_ARB_LOCK_EN: m1 holds lock across read then write of 0xBFC00010, while m0 also requests -> grant stays 10 for both transactions, then moves to 01.
